// File: rtl/grf_mp.sv
// Multi-port general register file with write-to-read bypass and a per-register busy scoreboard.
// Define GRF_TRACE_EN to print a line for every accepted write (simulation trace).
module grf_mp #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREAD*AW-1:0]  rd_addr,
  output logic [NREAD*DW-1:0]  rd_data,
  output logic [NREAD-1:0]     rd_busy,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic [NWRITE*DW-1:0] wr_data,
  input  logic [NWRITE*32-1:0] wr_pc,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [AW:0]          busy_cnt
);

  localparam int NREG = 2**AW;

  logic [DW-1:0]   regFile_q [NREG];
  logic [NREG-1:0] busyVec_q, busyVec_d;
  logic [AW:0]     busyCnt_q, busyCnt_d;

  // Clear on writeback first so that a same-cycle issue to the same register wins.
  always_comb begin
    busyVec_d = busyVec_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j]) busyVec_d[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (iss_en) busyVec_d[iss_addr] = 1'b1;
    busyVec_d[0] = 1'b0;
  end

  always_comb begin
    busyCnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      busyCnt_d = busyCnt_d + {{AW{1'b0}}, busyVec_d[r]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busyVec_q <= '0;
      busyCnt_q <= '0;
    end else begin
      busyVec_q <= busyVec_d;
      busyCnt_q <= busyCnt_d;
    end
  end

  // Ascending port order lets the highest-index port win a write conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regFile_q[r] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
          regFile_q[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] readAddr;
    logic [DW-1:0] readVal;
    rd_data  = '0;
    rd_busy  = '0;
    readAddr = '0;
    readVal  = '0;
    for (int k = 0; k < NREAD; k++) begin
      readAddr = rd_addr[k*AW +: AW];
      readVal  = regFile_q[readAddr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWRITE; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == readAddr))
            readVal = wr_data[j*DW +: DW];
        end
      end
      // Bypassed data must not leak out while reset is held.
      if (reset || (readAddr == '0)) readVal = '0;
      rd_data[k*DW +: DW] = readVal;
      rd_busy[k]          = busyVec_q[readAddr] && !reset;
    end
  end

  assign busy_cnt = busyCnt_q;

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    logic wonConflict;
    wonConflict = 1'b0;
    if (!reset) begin
      for (int j = 0; j < NWRITE; j++) begin
        wonConflict = wr_en[j] && (wr_addr[j*AW +: AW] != '0);
        for (int k = j + 1; k < NWRITE; k++) begin
          if (wr_en[k] && (wr_addr[k*AW +: AW] == wr_addr[j*AW +: AW])) wonConflict = 1'b0;
        end
        if (wonConflict)
          $display("%d@%h: $%d <= %h", $time, wr_pc[j*32 +: 32],
                   wr_addr[j*AW +: AW], wr_data[j*DW +: DW]);
      end
    end
  end
`else
  logic unusedTracePc;
  assign unusedTracePc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench for grf_mp (default parameters, bypass enabled).
module tb_grf_mp;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] wr_pc;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [5:0]  busy_cnt;

  int checkCount = 0;
  int passCount  = 0;

  grf_mp dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_pc    (wr_pc),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic iss, input logic [4:0] issa,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en    = wen;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    iss_en   = iss;
    iss_addr = issa;
    rd_addr  = {ra1, ra0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wr_pc = {32'h0040_0104, 32'h0040_0100};
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;

    for (int a = 0; a < 32; a++) begin
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
      #1;
      checkOutput("reset_rd0", rd_data[31:0], 32'h0);
      checkOutput("reset_rd1", rd_data[63:32], 32'h0);
      checkOutput("reset_busy", 32'(rd_busy), 32'h0);
    end
    checkOutput("reset_cnt", 32'(busy_cnt), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("post_reset_cnt", 32'(busy_cnt), 32'h0);

    applyStimulus(2'b01, 5'd5, 32'h1234_5678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    checkOutput("bypass_p0", rd_data[31:0], 32'h1234_5678);
    checkOutput("bypass_r0", rd_data[63:32], 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    #1;
    checkOutput("stored_r5_p0", rd_data[31:0], 32'h1234_5678);
    checkOutput("stored_r5_p1", rd_data[63:32], 32'h1234_5678);
    checkOutput("wb_nonbusy_busy", 32'(rd_busy), 32'h0);

    applyStimulus(2'b11, 5'd9, 32'hAAAA_0000, 5'd9, 32'h0000_BBBB, 1'b0, 5'd0, 5'd9, 5'd5);
    #1;
    checkOutput("conflict_bypass", rd_data[31:0], 32'h0000_BBBB);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
    #1;
    checkOutput("conflict_stored", rd_data[63:32], 32'h0000_BBBB);

    applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9);
    #1;
    checkOutput("r0_bypass", rd_data[31:0], 32'h0);
    checkOutput("r0_busy_now", 32'(rd_busy[0]), 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
    #1;
    checkOutput("r0_read", rd_data[31:0], 32'h0);
    checkOutput("r0_busy", 32'(rd_busy[0]), 32'h0);
    checkOutput("r0_cnt", 32'(busy_cnt), 32'h0);

    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
    tick();
    checkOutput("iss3_cnt", 32'(busy_cnt), 32'd1);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd4);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    #1;
    checkOutput("iss34_cnt", 32'(busy_cnt), 32'd2);
    checkOutput("iss34_busy", 32'(rd_busy), 32'h3);

    applyStimulus(2'b01, 5'd3, 32'h0000_0033, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
    #1;
    checkOutput("wbiss_busy_now", 32'(rd_busy), 32'h3);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    #1;
    checkOutput("wbiss_cnt", 32'(busy_cnt), 32'd2);
    checkOutput("wbiss_busy", 32'(rd_busy), 32'h3);
    checkOutput("wbiss_data", rd_data[31:0], 32'h0000_0033);

    applyStimulus(2'b10, 5'd0, 32'h0, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 5'd3, 5'd4);
    #1;
    checkOutput("wb4_pessimism", 32'(rd_busy), 32'h3);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    #1;
    checkOutput("wb4_cnt", 32'(busy_cnt), 32'd1);
    checkOutput("wb4_busy", 32'(rd_busy), 32'h1);
    checkOutput("wb4_data", rd_data[63:32], 32'h0000_0044);

    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd4);
    tick();
    checkOutput("reiss_cnt", 32'(busy_cnt), 32'd1);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3, 5'd4);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd8, 5'd3, 5'd4);
    tick();
    checkOutput("three_cnt", 32'(busy_cnt), 32'd3);

    applyStimulus(2'b01, 5'd9, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b1, 5'd10, 5'd3, 5'd9);
    #1;
    checkOutput("pre_rst_busy", 32'(rd_busy), 32'h1);
    checkOutput("pre_rst_data", rd_data[63:32], 32'hDEAD_BEEF);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_cnt", 32'(busy_cnt), 32'h0);
    checkOutput("async_busy", 32'(rd_busy), 32'h0);
    checkOutput("async_rd0", rd_data[31:0], 32'h0);
    checkOutput("async_rd1", rd_data[63:32], 32'h0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9);
    #1;
    reset = 1'b0;
    tick();
    checkOutput("after_rst_cnt", 32'(busy_cnt), 32'h0);
    checkOutput("after_rst_r9", rd_data[63:32], 32'h0);
    checkOutput("after_rst_r3", rd_data[31:0], 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file; successor to the single-write, two-read GRF.
- Sits in decode/writeback of the pipelined MIPS core.
- Adds configurable width/depth, N read and M write ports, and optional write-to-read bypass.
- Adds a per-register busy scoreboard, set at issue and cleared at writeback, used by the hazard unit for stall decisions.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; register count NREG = 2**AW.
- NREAD, 2, number of read ports (1..4).
- NWRITE, 2, number of write ports (1..2); higher index has priority.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads see stored value only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rd_addr  in  NREAD*AW  packed read addresses; port k at bits [k*AW +: AW].
- rd_data  out  NREAD*DW  packed read data; combinational.
- rd_busy  out  NREAD  scoreboard busy bit of each read address; combinational.
- wr_en  in  NWRITE  per-port write enable.
- wr_addr  in  NWRITE*AW  packed write addresses.
- wr_data  in  NWRITE*DW  packed write data.
- wr_pc  in  NWRITE*32  PC of the writing instruction; trace only.
- iss_en  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- busy_cnt  out  AW+1  registered count of busy registers.

Behaviour:
- Reset (async, active-high): all NREG registers <= 0, all busy bits <= 0, busy_cnt <= 0. Effect is immediate, independent of clk; rd_data reads 0 and rd_busy is 0 while reset is high.
- Register 0: a write to address 0 is dropped, and issue to address 0 is ignored. Reads of address 0 return 0, and rd_busy is 0, regardless of bypass.
- Write: on the clk edge, for each port j with wr_en[j]=1 and wr_addr[j]!=0, regs[wr_addr[j]] <= wr_data[j].
- Write conflict: if two ports target the same address, the highest-index port wins.
- Read with BYPASS=1: rd_data[k] = wr_data[j] of the highest-index j with wr_en[j]=1 and wr_addr[j]==rd_addr[k]!=0; otherwise regs[rd_addr[k]]. Zero-latency, write-first.
- Read with BYPASS=0: rd_data[k] = regs[rd_addr[k]]. A same-cycle write becomes visible on the next cycle.
- Scoreboard, per register r:
  - set  = iss_en && iss_addr==r
  - clr  = any wr_en[j] && wr_addr[j]==r
  - next = set ? 1 : (clr ? 0 : busy[r])
- Simultaneous issue and writeback to the same register: set wins. The new producer is pending; the old value is still written.
- Issue to an already busy register: busy stays 1 and busy_cnt is unchanged.
- Writeback to a non-busy register: data written, busy stays 0.
- rd_busy[k] = busy[rd_addr[k]], current-state value. Not bypassed by the same-cycle clear; the hazard unit tolerates one cycle of pessimism.
- busy_cnt: registered popcount of the next busy vector, updated every edge. Range 0..NREG-1, since register 0 is never busy; the AW+1 width has no overflow.
- Reset asserted mid-operation: pending writes and issues in that cycle are lost; busy_cnt returns to 0.

Optional Feature:
- Macro GRF_TRACE_EN.
- Defined: on each accepted write (wr_en=1, address !=0, after conflict resolution), emit $display("%d@%h: $%d <= %h", $time, wr_pc[j], wr_addr[j], wr_data[j]).
  - Write ports are printed in ascending port order.
  - A port that lost a conflict is not printed.
  - Writes to register 0 are not printed.
- Undefined: no display statements and no simulation-only logic; the wr_pc inputs are unused.

Test Plan:
- Reset then read all 32 addresses on both ports -> all rd_data = 0x00000000, rd_busy = 0, busy_cnt = 0.
- Write port0 $5=0x12345678; same cycle rd_addr0=5 -> rd_data0 = 0x12345678 (BYPASS=1), or old value 0 then 0x12345678 next cycle (BYPASS=0).
- Both ports write $9 in one cycle (p0=0xAAAA0000, p1=0x0000BBBB) -> regs[9] = 0x0000BBBB. Trace (GRF_TRACE_EN) prints only the p1 line.
- Write $0=0xFFFFFFFF with iss_en on $0 -> rd_data for address 0 = 0, rd_busy = 0, busy_cnt unchanged, no trace line.
- Issue $3, $4 -> busy_cnt = 2; next cycle writeback $3 and issue $3 together -> busy[3] stays 1, busy_cnt = 2; then writeback $4 -> busy_cnt = 1.
- busy_cnt = 3, pulse reset between clock edges -> busy_cnt, rd_busy and rd_data drop to 0 immediately, without waiting for a clk edge.
